// File: rtl/sint_eq_driver_pkg.sv
// -----------------------------------------------------------------------------
// sint_eq_driver_pkg
//   Shared types and helpers for the signed-equality sweep driver.
//   - state_t : driver FSM states (fixed encodings).
//   - smin/smax : bit patterns of the most negative / most positive signed
//     value of a given width, returned zero-extended in 32 bits. Callers
//     truncate to their operand width.
// -----------------------------------------------------------------------------
package sint_eq_driver_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRIVE    = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    // -2^(w-1): MSB set, everything else clear.
    function automatic logic [31:0] smin(input int w);
        return 32'd1 << (w - 1);
    endfunction

    // +2^(w-1)-1: MSB clear, everything else set.
    function automatic logic [31:0] smax(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/sint_pair_counter.sv
// -----------------------------------------------------------------------------
// sint_pair_counter
//   Nested sweep counter over every ordered pair (i0, i1) of signed WIDTH-bit
//   values, starting at (min, min) and ending at (max, max). i1 is the inner
//   (fast) digit; when it wraps from max back to min, i0 advances. Both digits
//   wrap modulo 2^WIDTH, which in two's complement walks min..-1,0..max.
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (pair returns to (min, min))
//   clr    in   synchronous clear to (min, min); wins over inc
//   inc    in   advance to the next pair
//   i0     out  outer operand
//   i1     out  inner operand
//   last   out  current pair is (max, max)
// -----------------------------------------------------------------------------
module sint_pair_counter
    import sint_eq_driver_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] i0,
    output logic [WIDTH-1:0] i1,
    output logic             last
);

    localparam logic [WIDTH-1:0] SMIN = WIDTH'(smin(WIDTH));
    localparam logic [WIDTH-1:0] SMAX = WIDTH'(smax(WIDTH));

    logic [WIDTH-1:0] i0_q;
    logic [WIDTH-1:0] i1_q;
    logic             i1_wrap;

    assign i1_wrap = (i1_q == SMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i0_q <= SMIN;
            i1_q <= SMIN;
        end else if (clr) begin
            i0_q <= SMIN;
            i1_q <= SMIN;
        end else if (inc) begin
            // Plain binary +1 is the signed successor with modulo wrap,
            // so max+1 lands on min without a special case.
            i1_q <= i1_q + WIDTH'(1);
            if (i1_wrap) begin
                i0_q <= i0_q + WIDTH'(1);
            end
        end
    end

    assign i0   = i0_q;
    assign i1   = i1_q;
    assign last = (i0_q == SMAX) && (i1_q == SMAX);

endmodule

// File: rtl/sint_eq_driver.sv
// -----------------------------------------------------------------------------
// sint_eq_driver
//   Self-test initiator for a WIDTH-bit signed equality comparator. On start
//   it offers every ordered operand pair over a valid/ready request channel,
//   waits for the 1-bit response of each, compares it against the expected
//   I0==I1 and counts mismatches (saturating). done/pass report the outcome
//   and stay up until the next start.
//
//   One request is outstanding at a time: DRIVE offers a pair, WAIT_RSP
//   waits for its response, then the pair advances. Responses arriving
//   outside WAIT_RSP are ignored.
//
// Optional build macro
//   SINT_EQ_DRIVER_FIRST_FAIL_EN : adds fail_valid/fail_i0/fail_i1, which
//   capture the operand pair of the first mismatch in a sweep.
//
// Ports
//   CLK          in   clock, rising edge
//   ASYNCRESETN  in   asynchronous active-low reset
//   start        in   pulse; starts a sweep from IDLE or DONE
//   I0, I1       out  operand pair to the comparator
//   req_valid    out  request valid (I0/I1 stable while not accepted)
//   req_ready    in   comparator accepts the request
//   rsp_valid    in   comparator response valid
//   rsp_eq       in   comparator result, 1 = equal
//   busy         out  sweep in progress
//   done         out  sweep finished, held until next start
//   pass         out  done with zero mismatches
//   err_count    out  mismatch count, saturates at all-ones
//   fail_valid   out  (optional) a mismatch has been captured this sweep
//   fail_i0/i1   out  (optional) operand pair of the first mismatch
// -----------------------------------------------------------------------------
module sint_eq_driver
    import sint_eq_driver_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNT_W = 2*WIDTH + 1
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             start,
    output logic [WIDTH-1:0] I0,
    output logic [WIDTH-1:0] I1,
    output logic             req_valid,
    input  logic             req_ready,
    input  logic             rsp_valid,
    input  logic             rsp_eq,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count
`ifdef SINT_EQ_DRIVER_FIRST_FAIL_EN
    ,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_i0,
    output logic [WIDTH-1:0] fail_i1
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic             pair_clr;
    logic             pair_inc;
    logic             pair_last;
    logic             exp_q;
    logic [CNT_W-1:0] err_q;
    logic             rsp_take;
    logic             mismatch;

    // -------------------------------------------------------------------------
    // Operand sweep
    // -------------------------------------------------------------------------
    sint_pair_counter #(
        .WIDTH (WIDTH)
    ) u_pair (
        .clk   (CLK),
        .rst_n (ASYNCRESETN),
        .clr   (pair_clr),
        .inc   (pair_inc),
        .i0    (I0),
        .i1    (I1),
        .last  (pair_last)
    );

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pair_clr  = 1'b0;
        pair_inc  = 1'b0;
        req_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = DRIVE;
                    pair_clr = 1'b1;
                end
            end
            DRIVE: begin
                req_valid = 1'b1;
                busy      = 1'b1;
                if (req_ready) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                busy = 1'b1;
                if (rsp_valid) begin
                    if (pair_last) begin
                        state_d = DONE;
                    end else begin
                        pair_inc = 1'b1;
                        state_d  = DRIVE;
                    end
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d  = DRIVE;
                    pair_clr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Expected value and error counter
    // -------------------------------------------------------------------------
    // The expected result is captured at the handshake so the check does not
    // depend on the operands still being on I0/I1 when the response returns.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            exp_q <= 1'b0;
        end else if (state_q == DRIVE && req_ready) begin
            exp_q <= (I0 == I1);
        end
    end

    assign rsp_take = (state_q == WAIT_RSP) && rsp_valid;
    assign mismatch = rsp_take && (rsp_eq != exp_q);

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            err_q <= '0;
        end else if (pair_clr) begin
            err_q <= '0;
        end else if (mismatch && (err_q != {CNT_W{1'b1}})) begin
            err_q <= err_q + CNT_W'(1);
        end
    end

    assign err_count = err_q;
    assign pass      = done && (err_q == '0);

    // -------------------------------------------------------------------------
    // First-failure capture
    // -------------------------------------------------------------------------
`ifdef SINT_EQ_DRIVER_FIRST_FAIL_EN
    logic             fail_vld_q;
    logic [WIDTH-1:0] fail_i0_q;
    logic [WIDTH-1:0] fail_i1_q;

    // Operands advance on the same edge the response is consumed, so I0/I1
    // still hold the pair under test while mismatch is evaluated.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            fail_vld_q <= 1'b0;
            fail_i0_q  <= '0;
            fail_i1_q  <= '0;
        end else if (pair_clr) begin
            fail_vld_q <= 1'b0;
            fail_i0_q  <= '0;
            fail_i1_q  <= '0;
        end else if (mismatch && !fail_vld_q) begin
            fail_vld_q <= 1'b1;
            fail_i0_q  <= I0;
            fail_i1_q  <= I1;
        end
    end

    assign fail_valid = fail_vld_q;
    assign fail_i0    = fail_i0_q;
    assign fail_i1    = fail_i1_q;
`endif

endmodule

// File: tb/tb_sint_eq_driver.sv
// -----------------------------------------------------------------------------
// tb_sint_eq_driver
//   Bench for sint_eq_driver (WIDTH=3). A comparator model answers requests
//   (ideal, one-pair-inverted, or stuck-at-0) with optional random ready
//   stalls and response delays. Expected operand pairs come from a nested
//   signed loop and are queued per sweep; a monitor pops one per handshake.
// -----------------------------------------------------------------------------
module tb_sint_eq_driver;

    localparam int WIDTH = 3;
    localparam int CNT_W = 2*WIDTH + 1;
    localparam int MINV  = -(1 << (WIDTH - 1));
    localparam int MAXV  = (1 << (WIDTH - 1)) - 1;
    localparam int NPAIR = 1 << (2*WIDTH);

    logic             CLK;
    logic             ASYNCRESETN;
    logic             start;
    logic [WIDTH-1:0] I0;
    logic [WIDTH-1:0] I1;
    logic             req_valid;
    logic             req_ready;
    logic             rsp_valid;
    logic             rsp_eq;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
`ifdef SINT_EQ_DRIVER_FIRST_FAIL_EN
    logic             fail_valid;
    logic [WIDTH-1:0] fail_i0;
    logic [WIDTH-1:0] fail_i1;
`endif

    sint_eq_driver #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .start       (start),
        .I0          (I0),
        .I1          (I1),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_eq      (rsp_eq),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err_count   (err_count)
`ifdef SINT_EQ_DRIVER_FIRST_FAIL_EN
        ,
        .fail_valid  (fail_valid),
        .fail_i0     (fail_i0),
        .fail_i1     (fail_i1)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int errors = 0;
    int checks = 0;

    logic [2*WIDTH-1:0] exp_q[$];
    int hs_cnt   = 0;
    int busy_cnt = 0;

    int resp_mode = 0;   // 0 ideal, 1 invert on (2,-2), 2 stuck-at-0
    bit rnd_en    = 1'b0;
    bit spur_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural comparator: what the unit under test answers for (a,b).
    function automatic bit model_eq(input int a, input int b, input int mode);
        if (mode == 2) return 1'b0;
        if (mode == 1 && a == 2 && b == -2) return !(a == b);
        return (a == b);
    endfunction

    // -------------------------------------------------------------------------
    // Comparator model: samples on negedge, drives 1 time unit after posedge.
    // -------------------------------------------------------------------------
    initial begin
        bit               hs;
        logic [WIDTH-1:0] hs_i0;
        logic [WIDTH-1:0] hs_i1;
        bit               pend;
        bit               pend_val;
        int               dly;
        int               rwait;
        pend  = 1'b0;
        pend_val = 1'b0;
        dly   = 0;
        rwait = 0;
        forever begin
            @(negedge CLK);
            hs    = req_valid && req_ready;
            hs_i0 = I0;
            hs_i1 = I1;
            @(posedge CLK);
            #1;
            rsp_valid = 1'b0;
            rsp_eq    = 1'b0;
            if (hs) begin
                pend     = 1'b1;
                pend_val = model_eq(int'($signed(hs_i0)), int'($signed(hs_i1)), resp_mode);
                dly      = rnd_en ? int'($urandom_range(0, 7)) : 0;
                rwait    = rnd_en ? int'($urandom_range(0, 5)) : 0;
            end
            if (pend) begin
                if (dly == 0) begin
                    rsp_valid = 1'b1;
                    rsp_eq    = pend_val;
                    pend      = 1'b0;
                end else begin
                    dly--;
                end
            end
            // Spurious wrong answer while a request is still being offered.
            if (spur_en && !rsp_valid && req_valid && (I0 == I1)) begin
                rsp_valid = 1'b1;
                rsp_eq    = 1'b0;
            end
            req_ready = (rwait == 0);
            if (req_valid && rwait > 0) rwait--;
        end
    end

    // -------------------------------------------------------------------------
    // Monitor: handshake scoreboard, operand hold check, busy cycle count.
    // -------------------------------------------------------------------------
    initial begin
        bit                 prev_stall;
        logic [WIDTH-1:0]   prev_i0;
        logic [WIDTH-1:0]   prev_i1;
        logic [2*WIDTH-1:0] exp_pair;
        prev_stall = 1'b0;
        prev_i0    = '0;
        prev_i1    = '0;
        forever begin
            @(negedge CLK);
            if (prev_stall && req_valid) begin
                check("hold", 32'({I0, I1}), 32'({prev_i0, prev_i1}));
            end
            prev_stall = req_valid && !req_ready;
            prev_i0    = I0;
            prev_i1    = I1;
            if (req_valid && req_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_handshake", 32'({I0, I1}), 32'hFFFF_FFFF);
                end else begin
                    exp_pair = exp_q.pop_front();
                    check("pair", 32'({I0, I1}), 32'(exp_pair));
                end
            end
            if (busy) busy_cnt++;
        end
    end

    task automatic pulse_start();
        @(posedge CLK);
        #1 start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    task automatic queue_sweep(input int mode, output int exp_err);
        exp_err = 0;
        for (int a = MINV; a <= MAXV; a++) begin
            for (int b = MINV; b <= MAXV; b++) begin
                exp_q.push_back({WIDTH'(a), WIDTH'(b)});
                if (model_eq(a, b, mode) != (a == b)) exp_err++;
            end
        end
    endtask

    task automatic run_sweep(input string tag, input int mode, input bit rnd,
                             input bit spur, input int exp_busy);
        int exp_err;
        int cyc;
        resp_mode = mode;
        rnd_en    = rnd;
        spur_en   = spur;
        queue_sweep(mode, exp_err);
        hs_cnt   = 0;
        busy_cnt = 0;
        pulse_start();
        cyc = 0;
        while (!done && cyc < 4000) begin
            @(posedge CLK);
            #1;
            cyc++;
            // A start while busy must not restart the sweep.
            start = (rnd && cyc == 40);
        end
        start = 1'b0;
        if (!done) check({tag, "_timeout"}, 32'(cyc), 32'd4000 + 32'd1);
        @(negedge CLK);
        check({tag, "_handshakes"}, 32'(hs_cnt), 32'(NPAIR));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_pass"}, 32'(pass), 32'(exp_err == 0));
        check({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
        check({tag, "_last_pair"}, 32'({I0, I1}), 32'({WIDTH'(MAXV), WIDTH'(MAXV)}));
        check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        if (exp_busy >= 0) check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    endtask

    initial begin
        int dummy;
        int cyc;
        ASYNCRESETN = 1'b0;
        start       = 1'b0;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_eq      = 1'b0;

        #12;
        check("rst_I0", 32'(I0), 32'b100);
        check("rst_I1", 32'(I1), 32'b100);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        repeat (2) @(posedge CLK);

        run_sweep("ideal", 0, 1'b0, 1'b0, 2*NPAIR);

        run_sweep("inv_one", 1, 1'b0, 1'b0, -1);
`ifdef SINT_EQ_DRIVER_FIRST_FAIL_EN
        check("fail_valid", 32'(fail_valid), 32'd1);
        check("fail_i0", 32'(fail_i0), 32'b010);
        check("fail_i1", 32'(fail_i1), 32'b110);
`endif

        run_sweep("random", 0, 1'b1, 1'b0, -1);
        run_sweep("spurious", 0, 1'b0, 1'b1, -1);

        // Abort mid-sweep with reset.
        resp_mode = 0;
        rnd_en    = 1'b0;
        spur_en   = 1'b0;
        queue_sweep(0, dummy);
        hs_cnt = 0;
        pulse_start();
        cyc = 0;
        while (hs_cnt < 20 && cyc < 500) begin
            @(posedge CLK);
            cyc++;
        end
        check("abort_reached_20", 32'(hs_cnt >= 20), 32'd1);
        #3 ASYNCRESETN = 1'b0;
        #1;
        check("abort_I0", 32'(I0), 32'b100);
        check("abort_I1", 32'(I1), 32'b100);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_req_valid", 32'(req_valid), 32'd0);
        check("abort_err", 32'(err_count), 32'd0);
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        repeat (20) @(posedge CLK);
        check("abort_idle_done", 32'(done), 32'd0);
        exp_q.delete();
        run_sweep("post_rst", 0, 1'b0, 1'b0, 2*NPAIR);

        run_sweep("stuck0_a", 2, 1'b0, 1'b0, -1);
        run_sweep("stuck0_b", 2, 1'b0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sint_eq_driver.md
Name: sint_eq_driver

Overview:
- Operand-side initiator for a W-bit signed equality unit.
- Sweeps every ordered pair of signed W-bit values over a valid/ready request channel.
- Collects the unit's 1-bit equality responses, checks each against the expected a==b, and reports mismatch count and pass/fail.
- Sits in on-chip self-test wrappers around SInt comparators.

Parameters:
- WIDTH, 3, operand width in bits; values are two's-complement signed.
- CNT_W, 2*WIDTH+1, width of the error counter; holds the worst case of 2^(2*WIDTH) errors.

Ports:
- CLK  in  1  clock, rising edge.
- ASYNCRESETN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- I0  out  WIDTH  operand A to the comparator.
- I1  out  WIDTH  operand B to the comparator.
- req_valid  out  1  I0/I1 are valid.
- req_ready  in  1  comparator accepts the request.
- rsp_valid  in  1  comparator response valid.
- rsp_eq  in  1  comparator result (1 = equal).
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; held until the next start.
- pass  out  1  done and err_count==0.
- err_count  out  CNT_W  number of mismatched responses.

Behaviour:
- Reset (async assert, sync-released use) forces:
  - state IDLE; I0 = I1 = -2^(WIDTH-1), i.e. MSB=1, rest 0.
  - req_valid, busy, done, pass = 0; err_count = 0.
- IDLE:
  - start=1 → DRIVE next cycle.
  - On entering DRIVE: err_count cleared, done/pass cleared, busy=1, both operands at the minimum value.
- DRIVE:
  - req_valid=1; I0/I1 held stable while req_ready=0.
  - Handshake on req_valid&req_ready: latch expected = (I0==I1) into exp_q, then → WAIT_RSP.
  - req_valid drops the cycle after the handshake.
- WAIT_RSP:
  - req_valid=0; waits any number of cycles for rsp_valid.
  - On rsp_valid: if rsp_eq != exp_q, err_count += 1, saturating at all-ones.
  - If the current pair is the last one (I0 = I1 = +2^(WIDTH-1)-1): → DONE.
  - Otherwise advance the pair, then → DRIVE. Order: I1 increments first; on I1 wrap from max to min, I0 increments. Signed wrap is plain modulo 2^WIDTH.
- rsp_valid while in DRIVE or IDLE is ignored; no count change.
- Exactly 2^(2*WIDTH) request handshakes per sweep. WIDTH=3 gives 64 pairs with 8 expected-equal responses.
- DONE:
  - busy=0; done=1; pass=(err_count==0).
  - Operands hold the last pair.
  - start=1 → re-enter DRIVE with a fresh sweep, same cycle behaviour as from IDLE.
- start while busy is ignored.
- ASYNCRESETN low mid-sweep aborts immediately to reset values; a response arriving after release is ignored.
- Single outstanding request only; the comparator must not return more than one response per request.

Optional Feature:
- Macro: SINT_EQ_DRIVER_FIRST_FAIL_EN.
- Defined:
  - Adds outputs fail_valid (1), fail_i0 (WIDTH), fail_i1 (WIDTH).
  - These capture the operand pair of the first mismatching response of the sweep. fail_valid is sticky until the next start or reset.
  - Reset/start values: fail_valid=0, fail_i0=fail_i1=0.
- Undefined: ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package sint_eq_driver_pkg holds:
  - state enum: IDLE=2'd0, DRIVE=2'd1, WAIT_RSP=2'd2, DONE=2'd3;
  - helper functions smin(WIDTH) and smax(WIDTH).
- One natural sub-module, sint_pair_counter: the nested I0/I1 signed sweep counter with increment, clear-to-min and last-pair flag.
- FSM, expected-value register and error counter remain in the top.

Test Plan:
- Ideal comparator model, req_ready=1, 1-cycle response, WIDTH=3, start pulse:
  - 64 handshakes, first pair (-4,-4), last pair (3,3);
  - done=1, pass=1, err_count=0;
  - total 64 × (1 DRIVE + 1 WAIT) = 128 busy cycles.
- Faulty model returning rsp_eq inverted for pair (2,-2) only → err_count=1, pass=0. With SINT_EQ_DRIVER_FIRST_FAIL_EN: fail_valid=1, fail_i0=3'b010, fail_i1=3'b110.
- Random req_ready low for 0–5 cycles and response delay 0–7 cycles:
  - I0/I1 stable whenever req_valid & !req_ready;
  - still exactly 64 handshakes; pass=1.
- Spurious rsp_valid=1 during DRIVE with rsp_eq=0 on an equal pair → no err_count change.
- Assert ASYNCRESETN low after 20 handshakes:
  - outputs take reset values asynchronously (I0=I1=3'b100, busy=0);
  - a new start completes a full clean sweep.
- Stuck-at-0 comparator (rsp_eq always 0) → err_count=8; a second start clears it and reproduces 8.
